// File: rtl/sram_controller.sv
// sram_controller: turns single-cycle requests into timed reads/writes on a 256x32 async SRAM.
// Define SRAM_CTRL_VERIFY_EN to read back every write and flag mismatches on err.
module sram_controller #(
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int READ_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    inout  wire  [31:0] mem_data,
    output logic [7:0]  mem_addrs,
    output logic        mem_we,
    output logic        mem_oe
);
    localparam int MAX_SP     = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_CYCLES = (MAX_SP > READ_CYCLES) ? MAX_SP : READ_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_OE, S_RD_END, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_WR_TURN, S_WR_END
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        mem_addrs_q, mem_addrs_d;
    logic [31:0]       dout_q, dout_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_oe_q, mem_oe_d;
    logic              drive_q, drive_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              last;
`ifdef SRAM_CTRL_VERIFY_EN
    logic              verify_q, verify_d;
    logic              err_q, err_d;
`endif

    assign last = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addrs_d = mem_addrs_q;
        dout_d      = dout_q;
        rdata_d     = rdata_q;
`ifdef SRAM_CTRL_VERIFY_EN
        verify_d    = verify_q;
        err_d       = err_q;
`endif
        case (state_q)
            // The END states are ready, so a new request can chain straight in
            S_IDLE, S_RD_END, S_WR_END: begin
                state_d = S_IDLE;
                if (req) begin
                    mem_addrs_d = addr;
                    dout_d      = wdata;
`ifdef SRAM_CTRL_VERIFY_EN
                    err_d       = 1'b0;
                    verify_d    = ~rw;
`endif
                    if (rw) begin
                        state_d = S_RD_OE;
                        cnt_d   = READ_LOAD;
                    end else begin
                        state_d = S_WR_SETUP;
                        cnt_d   = SETUP_LOAD;
                    end
                end
            end
            S_RD_OE: begin
                if (last) begin
                    rdata_d = mem_data;
`ifdef SRAM_CTRL_VERIFY_EN
                    if (verify_q) err_d = (mem_data != dout_q);
`endif
                    state_d = S_RD_END;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WR_SETUP: begin
                if (last) begin
                    state_d = S_WR_PULSE;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WR_PULSE: begin
                if (last) state_d = S_WR_HOLD;
                else      cnt_d   = cnt_q - 1'b1;
            end
            S_WR_HOLD: begin
`ifdef SRAM_CTRL_VERIFY_EN
                state_d = S_WR_TURN;
`else
                state_d = S_WR_END;
`endif
            end
            S_WR_TURN: begin
                state_d = S_RD_OE;
                cnt_d   = READ_LOAD;
            end
            default: state_d = S_IDLE;
        endcase

        // Pin values are decoded from the next state so every pin leaves a flop
        mem_we_d = (state_d != S_WR_PULSE);
        mem_oe_d = (state_d != S_RD_OE);
        drive_d  = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
        done_d   = (state_d == S_RD_END) || (state_d == S_WR_END);
        ready_d  = done_d || (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_addrs_q <= '0;
            dout_q      <= '0;
            rdata_q     <= '0;
            mem_we_q    <= 1'b1;
            mem_oe_q    <= 1'b1;
            drive_q     <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
`ifdef SRAM_CTRL_VERIFY_EN
            verify_q    <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addrs_q <= mem_addrs_d;
            dout_q      <= dout_d;
            rdata_q     <= rdata_d;
            mem_we_q    <= mem_we_d;
            mem_oe_q    <= mem_oe_d;
            drive_q     <= drive_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
`ifdef SRAM_CTRL_VERIFY_EN
            verify_q    <= verify_d;
            err_q       <= err_d;
`endif
        end
    end

    assign mem_data  = drive_q ? dout_q : 32'bz;
    assign mem_addrs = mem_addrs_q;
    assign mem_we    = mem_we_q;
    assign mem_oe    = mem_oe_q;
    assign ready     = ready_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
`ifdef SRAM_CTRL_VERIFY_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: vector table of reads/writes against a behavioural async SRAM,
// plus hand-written sequences for ignored requests, chaining, mid-write reset and verify errors.
module tb_sram_controller;
`ifdef SRAM_CTRL_VERIFY_EN
    localparam int WR_LAT = 8;
    localparam int WR_OE  = 2;
    localparam bit VERIFY = 1'b1;
`else
    localparam int WR_LAT = 5;
    localparam int WR_OE  = 0;
    localparam bit VERIFY = 1'b0;
`endif
    localparam int RD_LAT = 3;
    localparam int PULSE  = 2;
    localparam int RDCYC  = 2;

    logic        clk = 1'b0;
    logic        reset, req, rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        ready, done, err;
    logic [31:0] rdata;
    wire  [31:0] mem_data;
    logic [7:0]  mem_addrs;
    logic        mem_we, mem_oe;

    logic [31:0] sram [256];
    logic        corrupt;
    logic        probe_en;
    logic [31:0] probe_val;
    logic [31:0] last_wdata;

    int errors = 0;
    int checks = 0;

    sram_controller dut (
        .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .err(err),
        .mem_data(mem_data), .mem_addrs(mem_addrs), .mem_we(mem_we), .mem_oe(mem_oe)
    );

    always #5 clk = ~clk;

    // Async SRAM responder; corrupt clears bit 0 of anything it returns
    assign mem_data = (!mem_oe && mem_we) ?
                      (sram[mem_addrs] & (corrupt ? 32'hFFFF_FFFE : 32'hFFFF_FFFF)) : 32'bz;
    assign mem_data = probe_en ? probe_val : 32'bz;
    always @(posedge clk) if (!mem_we) sram[mem_addrs] <= mem_data;

    // Protocol monitor
    logic        rst_seen;
    logic        prev_we;
    logic [7:0]  prev_addrs;
    logic [31:0] prev_data;
    always @(posedge clk) rst_seen <= reset;
    always begin
        @(negedge clk);
        checks++;
        if (!mem_we && !mem_oe) begin
            errors++;
            $display("FAIL we_oe_overlap: we=%b oe=%b required not both low", mem_we, mem_oe);
        end
        if (!rst_seen && (!mem_we || !prev_we)) begin
            checks++;
            if (mem_addrs !== prev_addrs || mem_data !== prev_data) begin
                errors++;
                $display("FAIL we_window_stable: addr=%h data=%h required addr=%h data=%h",
                         mem_addrs, mem_data, prev_addrs, prev_data);
            end
        end
        prev_we    = mem_we;
        prev_addrs = mem_addrs;
        prev_data  = mem_data;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_released(input string name);
        probe_val = ~last_wdata;
        probe_en  = 1'b1;
        #1;
        check32(name, mem_data, probe_val);
        probe_en  = 1'b0;
    endtask

    // Called just after a negedge; returns just after the accepting posedge
    task automatic issue(input logic rw_i, input logic [7:0] addr_i, input logic [31:0] wdata_i);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check32("ready_before_issue", {31'd0, ready}, 32'd1);
        req   = 1'b1;
        rw    = rw_i;
        addr  = addr_i;
        wdata = wdata_i;
        if (!rw_i) last_wdata = wdata_i;
        @(posedge clk);
        #1;
        req   = 1'b0;
        rw    = 1'($urandom_range(0, 1));
        addr  = 8'($urandom);
        wdata = $urandom;
    endtask

    task automatic wait_done(input string name, input int exp_lat, input int exp_we,
                             input int exp_oe, input logic [31:0] exp_bus);
        int k, we_low, oe_low;
        k = 0; we_low = 0; oe_low = 0;
        do begin
            @(negedge clk);
            k++;
            if (!mem_we) begin
                we_low++;
                check32({name, "_bus_in_pulse"}, mem_data, exp_bus);
            end
            if (!mem_oe) oe_low++;
        end while (!done && k < 40);
        $display("txn %s: latency=%0d we_low=%0d oe_low=%0d rdata=%h err=%b",
                 name, k, we_low, oe_low, rdata, err);
        check32({name, "_latency"}, k, exp_lat);
        check32({name, "_we_low"}, we_low, exp_we);
        check32({name, "_oe_low"}, oe_low, exp_oe);
        check32({name, "_ready_with_done"}, {31'd0, ready}, 32'd1);
    endtask

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs [7];

    initial begin
        int ndone, first;
        vecs[0] = '{1'b0, 8'h3C, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 8'h3C, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b0, 8'h00, 32'h00000001, 32'h00000001};
        vecs[3] = '{1'b0, 8'hFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4] = '{1'b1, 8'h00, 32'h0,        32'h00000001};
        vecs[5] = '{1'b1, 8'hFF, 32'h0,        32'hFFFFFFFF};
        vecs[6] = '{1'b0, 8'h20, 32'hCAFEF00D, 32'hCAFEF00D};

        reset = 1'b1; req = 1'b0; rw = 1'b0; addr = 8'h0; wdata = 32'h0;
        corrupt = 1'b0; probe_en = 1'b0; probe_val = 32'h0; last_wdata = 32'h0;

        // Reset held two edges with random requests
        repeat (2) begin
            @(negedge clk);
            req = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
            addr = 8'($urandom); wdata = $urandom;
        end
        check32("rst_we", {31'd0, mem_we}, 32'd1);
        check32("rst_oe", {31'd0, mem_oe}, 32'd1);
        check32("rst_ready", {31'd0, ready}, 32'd1);
        check32("rst_done", {31'd0, done}, 32'd0);
        check32("rst_rdata", rdata, 32'd0);
        check32("rst_err", {31'd0, err}, 32'd0);
        check32("rst_addrs", {24'd0, mem_addrs}, 32'd0);
        check_released("rst_bus_released");
        reset = 1'b0; req = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].rw) wait_done($sformatf("vec%0d_rd", i), RD_LAT, 0, RDCYC, 32'h0);
            else            wait_done($sformatf("vec%0d_wr", i), WR_LAT, PULSE, WR_OE, vecs[i].wdata);
            if (vecs[i].rw || VERIFY) check32($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check32($sformatf("vec%0d_err", i), {31'd0, err}, 32'd0);
        end
        @(negedge clk);
        check_released("idle_bus_released");

        // Request during a write is ignored
        issue(1'b0, 8'h10, 32'h12345678);
        ndone = 0; first = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first == 0) first = k;
            end
            if (k == 2) begin req = 1'b1; rw = 1'b1; addr = 8'h20; end
            else req = 1'b0;
        end
        $display("txn midop_wr10: dones=%0d first_done=%0d", ndone, first);
        check32("midop_done_count", ndone, 32'd1);
        check32("midop_done_cycle", first, WR_LAT);
        check32("midop_ready", {31'd0, ready}, 32'd1);

        issue(1'b1, 8'h20, 32'h0);
        wait_done("rd20", RD_LAT, 0, RDCYC, 32'h0);
        check32("rd20_rdata", rdata, 32'hCAFEF00D);
        issue(1'b1, 8'h10, 32'h0);
        wait_done("b2b_rd10", RD_LAT, 0, RDCYC, 32'h0);
        check32("b2b_rd10_rdata", rdata, 32'h12345678);
        issue(1'b0, 8'h10, 32'h87654321);
        wait_done("wr10b", WR_LAT, PULSE, WR_OE, 32'h87654321);
        issue(1'b1, 8'h10, 32'h0);
        wait_done("b2b_rd10b", RD_LAT, 0, RDCYC, 32'h0);
        check32("b2b_rd10b_rdata", rdata, 32'h87654321);

        // Reset in the middle of the we pulse
        @(negedge clk);
        issue(1'b0, 8'h44, 32'h55AA55AA);
        @(negedge clk);
        @(negedge clk);
        check32("pre_reset_we_low", {31'd0, mem_we}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check32("midrst_we", {31'd0, mem_we}, 32'd1);
        check32("midrst_oe", {31'd0, mem_oe}, 32'd1);
        check32("midrst_ready", {31'd0, ready}, 32'd1);
        check32("midrst_done", {31'd0, done}, 32'd0);
        check32("midrst_rdata", rdata, 32'd0);
        check32("midrst_err", {31'd0, err}, 32'd0);
        check_released("midrst_bus_released");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(1'b1, 8'h3C, 32'h0);
        wait_done("post_rst_rd3c", RD_LAT, 0, RDCYC, 32'h0);
        check32("post_rst_rdata", rdata, 32'hDEADBEEF);

`ifdef SRAM_CTRL_VERIFY_EN
        // Readback corrupted on bit 0
        corrupt = 1'b1;
        issue(1'b0, 8'h50, 32'h00000001);
        wait_done("verify_bad", WR_LAT, PULSE, WR_OE, 32'h00000001);
        check32("verify_bad_err", {31'd0, err}, 32'd1);
        check32("verify_bad_rdata", rdata, 32'h00000000);
        corrupt = 1'b0;
        @(negedge clk);
        check32("verify_err_holds", {31'd0, err}, 32'd1);
        issue(1'b0, 8'h51, 32'h00000077);
        wait_done("verify_good", WR_LAT, PULSE, WR_OE, 32'h00000077);
        check32("verify_good_err", {31'd0, err}, 32'd0);
        check32("verify_good_rdata", rdata, 32'h00000077);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Clocked initiator for the 256x32 asynchronous SRAM responder, which has active-low we/oe, an 8-bit address and a 32-bit bidirectional data bus.
- Turns a single-cycle request on a simple handshake into a correctly sequenced SRAM read or write: address setup, we pulse, hold, oe window, bus turnaround.
- Sits between game logic (board-state storage) and the SRAM.
- Only this block drives the SRAM pins.

Parameters:
- SETUP_CYCLES, 1: cycles that address/data are stable with we high before the we pulse (min 1).
- PULSE_CYCLES, 2: cycles that we is held low (min 1).
- READ_CYCLES, 2: cycles that oe is low before read data is sampled (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only when ready=1.
- rw  in  1  1=read, 0=write; sampled with req.
- addr  in  8  word address; sampled with req.
- wdata  in  32  write data; sampled with req.
- ready  out  1  high when idle and able to accept req.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  last read (or verify readback) word; holds until the next read.
- err  out  1  write-verify mismatch flag (see Optional Feature).
- mem_data  inout  32  SRAM data bus; driven only during write states, else high-impedance.
- mem_addrs  out  8  SRAM address.
- mem_we  out  1  SRAM write enable, active low.
- mem_oe  out  1  SRAM output enable, active low.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset). All outputs are registered. No combinational path from req/rw/addr/wdata to any mem_* pin.
- Reset values: state IDLE, mem_we=1, mem_oe=1, mem_data high-impedance, mem_addrs=0, ready=1, done=0, rdata=0, err=0.
- IDLE:
  - ready=1; mem_we=1; mem_oe=1; bus released.
  - On an edge with req=1, latch rw/addr/wdata. ready=0 from the next cycle.
  - req while ready=0 is ignored, not queued.
- Read path:
  - RD_OE: mem_addrs=addr, mem_we=1, mem_oe=0, bus released. Held READ_CYCLES cycles.
  - mem_data is captured into rdata on the final RD_OE edge.
  - RD_END: mem_oe=1 (turnaround), done=1, ready=1, then IDLE.
  - Latency: done is high READ_CYCLES+1 cycles after the accept edge (defaults: 3).
- Write path:
  - WR_SETUP: mem_oe=1, mem_addrs=addr, mem_data driven with wdata, mem_we=1. Held SETUP_CYCLES cycles.
  - WR_PULSE: mem_we=0, addr/data unchanged. Held PULSE_CYCLES cycles.
  - WR_HOLD: mem_we=1, addr/data still driven for 1 cycle.
  - WR_END: bus released, done=1, ready=1, then IDLE.
  - Latency: SETUP_CYCLES+PULSE_CYCLES+2 cycles (defaults: 5).
- done and ready rise together. A new req may be accepted on the cycle done is high; it is sampled at the following edge.
- Invariants, checked by assertions:
  - Never mem_we=0 while mem_oe=0.
  - Controller never drives mem_data while mem_oe=0.
  - mem_addrs and mem_data are stable for the entire we-low window plus one cycle on each side.
  - oe low and bus driven never occur in the same or adjacent cycles (one-cycle turnaround).
- Phase counter: a single counter sized for max(SETUP,PULSE,READ) cycles, reloaded on each state entry.
- Reset mid-operation: at the next edge mem_we=1, mem_oe=1, bus released, state IDLE, done=0, rdata/err cleared. An aborted write leaves that SRAM word undefined.
- Address 0x00 and 0xFF have no special handling; there is no auto-increment and no wrap.

Optional Feature:
- Macro: SRAM_CTRL_VERIFY_EN.
- Defined:
  - After WR_HOLD, the bus is released for one turnaround cycle, then the full read sequence runs on the same address.
  - The readback goes to rdata. err is set at done when readback differs from the latched wdata, and is cleared at the next accepted req.
  - Write latency becomes SETUP+PULSE+READ_CYCLES+3 (defaults: 8).
- Undefined: err is tied to 0, there is no readback, and write latency is as above.

Test Plan:
- Reset: hold reset 2 cycles, drive random req -> mem_we=1, mem_oe=1, mem_data=z, ready=1, done=0, rdata=0.
- Write 0xDEADBEEF to 0x3C, then read 0x3C -> first done 5 cycles after accept; mem_we low exactly 2 cycles; second done 3 cycles later with rdata=0xDEADBEEF.
- Write 0x00000001 to 0x00 and 0xFFFFFFFF to 0xFF, then read both -> rdata 0x00000001 then 0xFFFFFFFF; no aliasing.
- Write 0x12345678 to 0x10; pulse req (read 0x20) mid-operation -> exactly one done; SRAM 0x20 untouched; back-to-back req on the done cycle is accepted.
- Assert reset during WR_PULSE -> next edge mem_we=1, bus z, ready=1; protocol assertions hold across all tests.
- With SRAM_CTRL_VERIFY_EN, bench forces mem_data bit 0 to 0 during readback of a write of 0x00000001 -> err=1 with done at cycle 8. A clean write gives err=0.
